// File: rtl/mdu_scheduler_pkg.sv
// Shared MDU encodings: operation codes, MTHILO/MFHILO selects, scheduler states
// and default latencies. Imported by decode-facing logic and the MDU itself.
package mdu_scheduler_pkg;

  typedef enum logic [3:0] {
    MDU_DUM   = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MADD  = 4'd5,
    MDU_MADDU = 4'd6,
    MDU_MSUB  = 4'd7,
    MDU_MSUBU = 4'd8
  } mdu_op_e;

  localparam logic [1:0] MTHILO_NONE = 2'b00;
  localparam logic [1:0] MTHILO_LO   = 2'b01;
  localparam logic [1:0] MTHILO_HI   = 2'b11;

  localparam logic [1:0] MFHILO_NONE = 2'b00;
  localparam logic [1:0] MFHILO_LO   = 2'b01;
  localparam logic [1:0] MFHILO_HI   = 2'b10;

  typedef enum logic [1:0] {
    MDU_S_IDLE = 2'd0,
    MDU_S_MUL  = 2'd1,
    MDU_S_DIV  = 2'd2
  } mdu_state_e;

  localparam int MDU_MULT_LAT = 5;
  localparam int MDU_DIV_LAT  = 10;

  function automatic logic is_mul_op(input logic [3:0] op);
    return op inside {MDU_MULT, MDU_MULTU, MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU};
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return op inside {MDU_DIV, MDU_DIVU};
  endfunction

endpackage

// File: rtl/mdu_scheduler_if.sv
// E-stage <-> MDU bundle: issue controls and operands from the pipeline,
// busy/stall/read data and debug HI/LO back from the MDU.
interface mdu_scheduler_if;
  logic        issue;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  mthilo;
  logic [1:0]  mfhilo;
  logic        d_uses_mdu;
  logic        busy;
  logic        stall;
  logic [31:0] rdata;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output issue, op, a, b, mthilo, mfhilo, d_uses_mdu,
    input  busy, stall, rdata, hi, lo
  );

  modport slave (
    input  issue, op, a, b, mthilo, mfhilo, d_uses_mdu,
    output busy, stall, rdata, hi, lo
  );
endinterface

// File: rtl/mdu_scheduler_arith.sv
// Purely combinational MDU datapath: computes the committed {HI,LO} from the
// latched op, operands and the {HI,LO} captured at issue.
module mdu_arith
  import mdu_scheduler_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [63:0]        acc;
  logic [63:0]        sext_a;
  logic [63:0]        sext_b;
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic               div_ovf;
  logic               div_zero;
  logic signed [31:0] sa;
  logic signed [31:0] sb;
  logic signed [31:0] q_s;
  logic signed [31:0] r_s;
  logic [31:0]        bu;
  logic [31:0]        q_u;
  logic [31:0]        r_u;
  logic [63:0]        res;

  assign acc    = {hi_i, lo_i};
  assign sext_a = {{32{a_i[31]}}, a_i};
  assign sext_b = {{32{b_i[31]}}, b_i};
  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign prod_s = sext_a * sext_b;
  assign prod_u = {32'b0, a_i} * {32'b0, b_i};

  // Substituting divisor 1 for -1 on the overflow case yields exactly LO=a, HI=0.
  assign div_zero = (b_i == 32'd0);
  assign div_ovf  = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
  assign sa       = a_i;
  assign sb       = (div_ovf || div_zero) ? 32'd1 : b_i;
  assign q_s      = sa / sb;
  assign r_s      = sa % sb;
  assign bu       = div_zero ? 32'd1 : b_i;
  assign q_u      = a_i / bu;
  assign r_u      = a_i % bu;

  always_comb begin
    res = acc;
    case (op_i)
      MDU_MULT:  res = prod_s;
      MDU_MULTU: res = prod_u;
      MDU_MADD:  res = acc + prod_s;
      MDU_MADDU: res = acc + prod_u;
      MDU_MSUB:  res = acc - prod_s;
      MDU_MSUBU: res = acc - prod_u;
      MDU_DIV:   res = div_zero ? acc : {r_s, q_s};
      MDU_DIVU:  res = div_zero ? acc : {r_u, q_u};
      default:   res = acc;
    endcase
  end

  assign {hi_o, lo_o} = res;

endmodule

// File: rtl/mdu_scheduler.sv
// MDU controller in the E stage: owns HI/LO, models fixed multiply/divide
// latency with a busy FSM, and stalls MDU-dependent instructions in D.
module mdu_scheduler
  import mdu_scheduler_pkg::*;
#(
  parameter int MULT_LAT = MDU_MULT_LAT,
  parameter int DIV_LAT  = MDU_DIV_LAT
) (
  input  logic           clk,
  input  logic           rst_n,
  mdu_scheduler_if.slave bus
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 1);

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [3:0]       op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [31:0]      acc_hi_q;
  logic [31:0]      acc_lo_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             start_mul;
  logic             start_div;

  mdu_arith u_arith (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .hi_i (acc_hi_q),
    .lo_i (acc_lo_q),
    .hi_o (res_hi),
    .lo_o (res_lo)
  );

  assign start_mul = bus.issue && is_mul_op(bus.op);
  assign start_div = bus.issue && is_div_op(bus.op);

  // Issues while busy are dropped; the pipeline is expected never to send them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MDU_S_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      op_q     <= MDU_DUM;
      a_q      <= '0;
      b_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state_q)
        MDU_S_IDLE: begin
          if (start_mul || start_div) begin
            state_q  <= start_div ? MDU_S_DIV : MDU_S_MUL;
            cnt_q    <= start_div ? DIV_INIT : MUL_INIT;
            busy_q   <= 1'b1;
            op_q     <= bus.op;
            a_q      <= bus.a;
            b_q      <= bus.b;
            acc_hi_q <= hi_q;
            acc_lo_q <= lo_q;
          end else if (bus.issue && (bus.op == MDU_DUM)) begin
            if (bus.mthilo == MTHILO_HI) hi_q <= bus.a;
            if (bus.mthilo == MTHILO_LO) lo_q <= bus.a;
          end
        end
        MDU_S_MUL, MDU_S_DIV: begin
          if (cnt_q == '0) begin
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            busy_q  <= 1'b0;
            state_q <= MDU_S_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= MDU_S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.rdata = 32'd0;
    case (bus.mfhilo)
      MFHILO_HI: bus.rdata = hi_q;
      MFHILO_LO: bus.rdata = lo_q;
      default:   bus.rdata = 32'd0;
    endcase
  end

  assign bus.busy  = busy_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.stall = bus.d_uses_mdu & (busy_q | (bus.issue & (bus.op != MDU_DUM)));

endmodule

// File: doc/mdu_scheduler.md
# mdu_scheduler

Multi-cycle multiply/divide unit controller for the 5-stage MIPS pipeline, sitting in the E stage beside the ALU. It accepts the `MDUOp`, `MTHILO` and `MFHILO` controls produced by decode, owns the HI/LO registers, and models fixed multiply and divide latencies with a busy state machine. It raises a stall to hold D-stage MDU-dependent instructions until HI/LO are final.

## Interface
- `MULT_LAT`, default 5: cycles from issue to HI/LO commit for MULT/MULTU/MADD/MADDU/MSUB/MSUBU.
- `DIV_LAT`, default 10: cycles from issue to HI/LO commit for DIV/DIVU.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `issue`  in  1  E-stage instruction is valid; qualifies `op` and `mthilo`.
- `op`  in  4  MDU operation code; `MDU_DUM` means none.
- `a`  in  32  rs operand; also MTHI/MTLO write data.
- `b`  in  32  rt operand.
- `mthilo`  in  2  01 = write LO, 11 = write HI, 00 = none.
- `mfhilo`  in  2  01 = read LO, 10 = read HI, 00 = none.
- `d_uses_mdu`  in  1  D-stage instruction has non-DUM MDUOp, or non-zero MTHILO or MFHILO.
- `busy`  out  1  operation in flight.
- `stall`  out  1  freeze F/D, bubble into E.
- `rdata`  out  32  MFHI/MFLO result.
- `hi`, `lo`  out  32 each  architectural HI/LO, for debug.

## Operation
- States: IDLE, MUL, DIV. A down-counter `cnt` holds the remaining cycles.
- IDLE:
  - `issue` with a multiply-class op → MUL, `cnt=MULT_LAT-1`.
  - `issue` with DIV/DIVU → DIV, `cnt=DIV_LAT-1`.
  - In both cases the operands, op, and the current {HI,LO} are latched.
- MUL/DIV: `cnt` decrements each cycle. When `cnt==0`, the next edge commits the 64-bit result to {HI,LO} and returns to IDLE.
- Arithmetic on the latched values:
  - MULT: signed 32×32→64. MULTU: unsigned.
  - MADD/MSUB: {HI,LO} ± signed product. MADDU/MSUBU: unsigned product. All mod 2^64.
  - DIV: signed; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend. 0x80000000 / -1 gives LO=0x80000000, HI=0.
  - DIVU: unsigned.
  - Divide by zero: the full DIV_LAT cycles elapse, and HI/LO are left unchanged at commit.
- MTHI/MTLO: with `issue` in IDLE and no multiply/divide op, `a` is written to the selected register at the edge. If `op` is non-DUM in the same cycle, `op` wins and the write is dropped.
- `issue` with a non-DUM op, or a non-zero `mthilo`, while busy is ignored. This is a protocol violation; the bench asserts it never occurs.
- `rdata` is combinational from the architectural HI/LO: HI for 10, LO for 01, 0 for 00 or 11.
- `stall = d_uses_mdu & (busy | (issue & op != MDU_DUM))`.

## Timing
- Reset (async assert, any state, including mid-operation):
  - State goes to IDLE, `cnt=0`, HI=LO=0.
  - `busy=0`, `stall` reflects inputs only, `rdata=0`.
  - The in-flight result is discarded.
- Issue in cycle t:
  - `busy=1` during cycles t+1 … t+LAT.
  - HI/LO are updated at the edge ending cycle t+LAT.
  - `busy=0` and the new value is visible on `rdata` in cycle t+LAT+1.
- Back-to-back operation: a new issue is accepted in the first cycle with `busy=0`. No dead cycle.
- `stall` is combinational, same cycle as its causes. `busy` is registered.

## Structure
- `MDU_*` op codes and the `MTHILO`/`MFHILO` encodings live in `macro.vh`, shared with decode.
- Add to `macro.vh`: state encodings `MDU_S_IDLE/MUL/DIV`, plus `MDU_MULT_LAT`/`MDU_DIV_LAT` defaults.
- One sub-module, `mdu_arith`: purely combinational `(op, a, b, hi, lo) → {hi_n, lo_n}`.
- `mdu_scheduler` holds the FSM, counter, operand/HI/LO latches and stall logic.

## Test plan
- MULT a=0xFFFFFFFE (-2), b=3, then MFLO in D → `stall=1` for 6 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA at cycle t+5 edge; `rdata`=0xFFFFFFFA after.
- DIV a=-7, b=2 → `busy` 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 → HI/LO unchanged after 10 cycles.
- MTHI a=1, MTLO a=0xFFFFFFFF, then MADDU a=1, b=1 → after 5 cycles HI=2, LO=0. MSUB a=1, b=1 from HI=LO=0 → HI=LO=0xFFFFFFFF.
- MULT issued, `rst_n` pulsed low at cycle t+2 → `busy=0` immediately; HI=LO=0; no commit at t+5.
- Back-to-back: MULTU 0xFFFFFFFF×0xFFFFFFFF followed by a DIVU issued in the first non-busy cycle → accepted. After the MULTU, HI=0xFFFFFFFE, LO=0x00000001. The DIVU result is committed 10 cycles later.
- D-stage ADDU while busy (`d_uses_mdu=0`) → `stall=0`. Concurrent `op` + `mthilo` in IDLE → op executes, MT write dropped.
